// File: rtl/snos_pkg.sv
// Shared constants for the SNOS board glue: I2S bundle width, idle timeout default
// and the jumper-selected LED mode encoding.
package snos_pkg;

    localparam int I2S_BITS            = 3;      // {bck, lrck, data}
    localparam int DEFAULT_IDLE_CYCLES = 65536;

    typedef enum logic [1:0] {
        LED_OFF      = 2'b00,
        LED_BCK      = 2'b01,
        LED_BCK_MUTE = 2'b10,
        LED_BCK_PLL  = 2'b11
    } led_mode_t;

endpackage

// File: rtl/snos_act_mon.sv
// Activity monitor: 2-FF synchronizer, edge detect and a timeout counter that
// reloads on each edge; active while the counter is non-zero.
module snos_act_mon
    import snos_pkg::*;
#(
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic clk,
    input  logic reset_mcu,
    input  logic din,
    output logic active
);

    localparam int CW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(IDLE_CYCLES - 1);

    logic          s1, s2, prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_mcu) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            // An edge in the same cycle as expiry still reloads.
            if (s2 != prev)
                cnt <= RELOAD;
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    assign active = (cnt != '0);

endmodule

// File: rtl/snos_top.sv
// SNOS audio board glue: re-times MCU I2S into clk, maps MCU control to the DAC
// under jumper overrides, drives indicators/LEDs. Option: SNOS_MUTE_ON_IDLE_EN.
module snos_top
    import snos_pkg::*;
#(
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic        clk,
    input  logic        reset_mcu,
    input  logic [15:1] j,
    input  logic        mclk_in,
    output logic        mclk_out,
    output logic        pll_clk,
    input  logic        pll_clkout,
    output logic [1:0]  pll_s,
    input  logic        i2s_mcu_bck,
    input  logic        i2s_mcu_lrck,
    input  logic        i2s_mcu_data,
    output logic        i2s_dac_bck,
    output logic        i2s_dac_lrck,
    output logic        i2s_dac_data,
    output logic        i2s_dac_data_r,
    input  logic        mcu_44_48,
    input  logic        mcu_mute,
    input  logic        mcu_dsd_on,
    input  logic        mcu_dac_reset,
    input  logic        mcu_p_d,
    input  logic [1:0]  mcu_f,
    input  logic        mcu_bit_6,
    input  logic        mcu_bit_8,
    input  logic        mcu_bit_10,
    input  logic        mcu_d5,
    input  logic        mcu_d7,
    input  logic        mcu_d9,
    output logic        dac_44_48,
    output logic        dac_mute,
    output logic        dac_dsd,
    output logic        dac_reset,
    output logic [1:0]  dac_f,
    output logic        p_d,
    output logic        bit_6,
    output logic        bit_8,
    output logic        bit_10,
    output logic        d_5,
    output logic        d_7,
    output logic        d_9,
    output logic        p_x8,
    output logic [2:1]  led
);

    logic [I2S_BITS-1:0] i2s_s1, i2s_s2;
    logic                bck_active, pll_active;
    logic [1:0]          f_next;
    logic                mute_next;
    logic [2:1]          led_next;
    logic                unused_jumper;

    assign mclk_out      = mclk_in;
    assign pll_clk       = mclk_in;
    assign unused_jumper = j[13];

    snos_act_mon #(.IDLE_CYCLES(IDLE_CYCLES)) u_bck_mon (
        .clk       (clk),
        .reset_mcu (reset_mcu),
        .din       (i2s_mcu_bck),
        .active    (bck_active)
    );

    snos_act_mon #(.IDLE_CYCLES(IDLE_CYCLES)) u_pll_mon (
        .clk       (clk),
        .reset_mcu (reset_mcu),
        .din       (pll_clkout),
        .active    (pll_active)
    );

    always_comb begin
        f_next    = (mcu_f < j[4:3]) ? mcu_f : j[4:3];
`ifdef SNOS_MUTE_ON_IDLE_EN
        mute_next = mcu_mute | ~j[1] | ~bck_active;
`else
        mute_next = mcu_mute | ~j[1];
`endif
        case (led_mode_t'(j[12:11]))
            LED_BCK_PLL:  led_next = {pll_active, bck_active};
            LED_BCK_MUTE: led_next = {mute_next, bck_active};
            LED_BCK:      led_next = {2{bck_active}};
            default:      led_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_mcu) begin
            i2s_s1         <= '0;
            i2s_s2         <= '0;
            i2s_dac_bck    <= 1'b0;
            i2s_dac_lrck   <= 1'b0;
            i2s_dac_data   <= 1'b0;
            i2s_dac_data_r <= 1'b0;
            dac_mute       <= 1'b1;
            dac_dsd        <= 1'b1;
            dac_reset      <= 1'b0;
            dac_f          <= 2'b00;
            dac_44_48      <= 1'b0;
            pll_s          <= 2'b00;
            p_d            <= 1'b0;
            bit_6          <= 1'b0;
            bit_8          <= 1'b0;
            bit_10         <= 1'b0;
            d_5            <= 1'b0;
            d_7            <= 1'b0;
            d_9            <= 1'b0;
            p_x8           <= 1'b0;
            led            <= 2'b00;
        end else begin
            i2s_s1         <= {i2s_mcu_bck, i2s_mcu_lrck, i2s_mcu_data};
            i2s_s2         <= i2s_s1;
            i2s_dac_bck    <= i2s_s2[2];
            i2s_dac_lrck   <= i2s_s2[1];
            // Open j[15] lets audio through; fitted jumper silences both data lines.
            i2s_dac_data   <= i2s_s2[0] & j[15];
            i2s_dac_data_r <= i2s_s2[0] & i2s_s2[1] & j[15];
            dac_mute       <= mute_next;
            dac_dsd        <= j[2] ? mcu_dsd_on : 1'b1;
            dac_reset      <= mcu_dac_reset ^ j[6];
            dac_f          <= f_next;
            dac_44_48      <= j[5] & mcu_44_48;
            pll_s          <= j[14] ? 2'b00 : f_next;
            p_d            <= mcu_p_d;
            bit_6          <= mcu_bit_6 & j[7];
            bit_8          <= mcu_bit_8 & j[8];
            bit_10         <= mcu_bit_10 & j[9];
            d_5            <= mcu_d5;
            d_7            <= mcu_d7;
            d_9            <= mcu_d9;
            p_x8           <= j[10] & (f_next == 2'b11);
            led            <= led_next;
        end
    end

endmodule

// File: tb/tb_snos_top.sv
// Self-checking bench for snos_top: reset, I2S re-timing with mid-stream reset,
// control/indicator mapping with random jumpers, and the bck idle timeout.
module tb_snos_top;

    localparam int IDLE = 40;

    logic        clk = 1'b0;
    logic        reset_mcu;
    logic [15:1] j;
    logic        mclk_in, mclk_out, pll_clk, pll_clkout;
    logic [1:0]  pll_s;
    logic        i2s_mcu_bck, i2s_mcu_lrck, i2s_mcu_data;
    logic        i2s_dac_bck, i2s_dac_lrck, i2s_dac_data, i2s_dac_data_r;
    logic        mcu_44_48, mcu_mute, mcu_dsd_on, mcu_dac_reset, mcu_p_d;
    logic [1:0]  mcu_f;
    logic        mcu_bit_6, mcu_bit_8, mcu_bit_10, mcu_d5, mcu_d7, mcu_d9;
    logic        dac_44_48, dac_mute, dac_dsd, dac_reset;
    logic [1:0]  dac_f;
    logic        p_d, bit_6, bit_8, bit_10, d_5, d_7, d_9, p_x8;
    logic [2:1]  led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snos_top #(.IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .reset_mcu(reset_mcu), .j(j),
        .mclk_in(mclk_in), .mclk_out(mclk_out), .pll_clk(pll_clk),
        .pll_clkout(pll_clkout), .pll_s(pll_s),
        .i2s_mcu_bck(i2s_mcu_bck), .i2s_mcu_lrck(i2s_mcu_lrck), .i2s_mcu_data(i2s_mcu_data),
        .i2s_dac_bck(i2s_dac_bck), .i2s_dac_lrck(i2s_dac_lrck),
        .i2s_dac_data(i2s_dac_data), .i2s_dac_data_r(i2s_dac_data_r),
        .mcu_44_48(mcu_44_48), .mcu_mute(mcu_mute), .mcu_dsd_on(mcu_dsd_on),
        .mcu_dac_reset(mcu_dac_reset), .mcu_p_d(mcu_p_d), .mcu_f(mcu_f),
        .mcu_bit_6(mcu_bit_6), .mcu_bit_8(mcu_bit_8), .mcu_bit_10(mcu_bit_10),
        .mcu_d5(mcu_d5), .mcu_d7(mcu_d7), .mcu_d9(mcu_d9),
        .dac_44_48(dac_44_48), .dac_mute(dac_mute), .dac_dsd(dac_dsd),
        .dac_reset(dac_reset), .dac_f(dac_f),
        .p_d(p_d), .bit_6(bit_6), .bit_8(bit_8), .bit_10(bit_10),
        .d_5(d_5), .d_7(d_7), .d_9(d_9), .p_x8(p_x8), .led(led)
    );

    // Reference I2S delay line: one entry per clk edge, holding the inputs
    // sampled at that edge and whether reset was released at that edge.
    typedef struct packed {
        logic rst;
        logic bck;
        logic lrck;
        logic data;
    } smp_t;
    smp_t hist[$];
    logic cur_j15;

    task automatic test_reset();
        reset_mcu = 1'b0;
        j = '1;
        mcu_mute = 1'b0; mcu_dsd_on = 1'b0; mcu_dac_reset = 1'b1; mcu_f = 2'b11;
        mcu_44_48 = 1'b1; mcu_p_d = 1'b1; mcu_bit_6 = 1'b1; mcu_bit_8 = 1'b1;
        mcu_bit_10 = 1'b1; mcu_d5 = 1'b1; mcu_d7 = 1'b1; mcu_d9 = 1'b1;
        i2s_mcu_bck = 1'b1; i2s_mcu_lrck = 1'b1; i2s_mcu_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dac_mute, dac_reset, dac_dsd, dac_f, dac_44_48, pll_s} !== 8'b1_0_1_00_0_00) begin
            errors++;
            $display("FAIL reset_ctl got mute=%b rst=%b dsd=%b f=%b 4448=%b pll_s=%b exp 1 0 1 00 0 00",
                     dac_mute, dac_reset, dac_dsd, dac_f, dac_44_48, pll_s);
        end
        checks++;
        if ({i2s_dac_bck, i2s_dac_lrck, i2s_dac_data, i2s_dac_data_r, led} !== 6'b0) begin
            errors++;
            $display("FAIL reset_i2s_led got i2s=%b%b%b%b led=%b exp 0000 00",
                     i2s_dac_bck, i2s_dac_lrck, i2s_dac_data, i2s_dac_data_r, led);
        end
        checks++;
        if ({p_d, bit_6, bit_8, bit_10, d_5, d_7, d_9, p_x8} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ind got %b exp 00000000",
                     {p_d, bit_6, bit_8, bit_10, d_5, d_7, d_9, p_x8});
        end
        // Reset stays asserted; the reference line starts from a cleared pipeline.
        hist.delete();
        repeat (3) hist.push_back(smp_t'(0));
        cur_j15 = 1'b1;
    endtask

    task automatic i2s_step(input logic rst, input logic b, input logic l,
                            input logic d, input logic j15);
        logic ok, eb, el, ed, er;
        @(negedge clk);
        ok = hist[0].rst & hist[1].rst & hist[2].rst;
        eb = ok & hist[0].bck;
        el = ok & hist[0].lrck;
        ed = ok & hist[0].data & cur_j15;
        er = ed & el;
        checks++;
        if ({i2s_dac_bck, i2s_dac_lrck, i2s_dac_data, i2s_dac_data_r} !== {eb, el, ed, er}) begin
            errors++;
            $display("FAIL i2s_path t=%0t got bck/lrck/data/data_r=%b%b%b%b exp %b%b%b%b", $time,
                     i2s_dac_bck, i2s_dac_lrck, i2s_dac_data, i2s_dac_data_r, eb, el, ed, er);
        end
        if (!hist[2].rst) begin
            checks++;
            if ({dac_mute, led} !== 3'b100) begin
                errors++;
                $display("FAIL midreset_ctl t=%0t got mute=%b led=%b exp 1 00", $time, dac_mute, led);
            end
        end
        reset_mcu = rst;
        i2s_mcu_bck = b; i2s_mcu_lrck = l; i2s_mcu_data = d;
        j[15] = j15; cur_j15 = j15;
        hist.push_back('{rst: rst, bck: b, lrck: l, data: d});
        void'(hist.pop_front());
    endtask

    task automatic test_i2s_passthrough();
        logic lr, dat, rst, j15;
        repeat (3) i2s_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int fr = 0; fr < 128; fr++) begin
            j15 = (fr < 96);
            for (int b = 0; b < 32; b++) begin
                lr  = (b >= 16);
                dat = 1'($urandom);
                rst = !(fr == 60 && b >= 5 && b < 7);
                repeat ($urandom_range(2, 3)) i2s_step(rst, 1'b0, lr, dat, j15);
                repeat ($urandom_range(2, 3)) i2s_step(rst, 1'b1, lr, dat, j15);
            end
        end
        // Drain the pipeline against the reference.
        repeat (4) i2s_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_control();
        logic       e_mute, e_dsd, e_rst, e_4448, e_px8, e_valid;
        logic [1:0] e_f, e_pll, jf;
        logic [2:1] e_led;
        logic [6:0] e_ind;
        e_valid = 1'b0;
        reset_mcu = 1'b1;
        for (int i = -8; i <= 200; i++) begin
            @(negedge clk);
            if (e_valid) begin
                checks++;
                if ({dac_mute, dac_dsd, dac_reset, dac_44_48, dac_f} !== {e_mute, e_dsd, e_rst, e_4448, e_f}) begin
                    errors++;
                    $display("FAIL ctl_map i=%0d got mute/dsd/rst/4448/f=%b%b%b%b%b exp %b%b%b%b%b", i,
                             dac_mute, dac_dsd, dac_reset, dac_44_48, dac_f,
                             e_mute, e_dsd, e_rst, e_4448, e_f);
                end
                checks++;
                if ({pll_s, p_x8, led} !== {e_pll, e_px8, e_led}) begin
                    errors++;
                    $display("FAIL pll_led i=%0d got pll_s=%b p_x8=%b led=%b exp %b %b %b", i,
                             pll_s, p_x8, led, e_pll, e_px8, e_led);
                end
                checks++;
                if ({p_d, bit_6, bit_8, bit_10, d_5, d_7, d_9} !== e_ind) begin
                    errors++;
                    $display("FAIL indicators i=%0d got %b exp %b", i,
                             {p_d, bit_6, bit_8, bit_10, d_5, d_7, d_9}, e_ind);
                end
            end
            // Keep both monitored clocks toggling so both report active.
            if ((i & 1) == 0) begin
                i2s_mcu_bck = ~i2s_mcu_bck;
                pll_clkout  = ~pll_clkout;
            end
            {mcu_44_48, mcu_mute, mcu_dsd_on, mcu_dac_reset, mcu_p_d} = 5'($urandom);
            {mcu_bit_6, mcu_bit_8, mcu_bit_10, mcu_d5, mcu_d7, mcu_d9} = 6'($urandom);
            mcu_f = 2'($urandom);
            j = 15'($urandom);
            if (i == 0) begin
                mcu_f = 2'b11; j[4:3] = 2'b01; j[10] = 1'b1; j[14] = 1'b0;
            end else if (i == 1) begin
                j[1] = 1'b0; mcu_mute = 1'b0; j[2] = 1'b0; mcu_dsd_on = 1'b0;
            end
            mclk_in = 1'($urandom);
            #1;
            checks++;
            if ({mclk_out, pll_clk} !== {2{mclk_in}}) begin
                errors++;
                $display("FAIL mclk_copy got %b%b exp %b%b", mclk_out, pll_clk, mclk_in, mclk_in);
            end
            jf      = j[4:3];
            e_f     = (int'(mcu_f) < int'(jf)) ? mcu_f : jf;
            e_mute  = mcu_mute || !j[1];
            e_dsd   = j[2] ? mcu_dsd_on : 1'b1;
            e_rst   = (mcu_dac_reset != j[6]);
            e_4448  = j[5] && mcu_44_48;
            e_pll   = j[14] ? 2'b00 : e_f;
            e_px8   = j[10] && (e_f == 2'd3);
            e_ind   = {mcu_p_d, mcu_bit_6 & j[7], mcu_bit_8 & j[8], mcu_bit_10 & j[9],
                       mcu_d5, mcu_d7, mcu_d9};
            case (int'(j[12:11]))
                3:       e_led = 2'b11;
                2:       e_led = {e_mute, 1'b1};
                1:       e_led = 2'b11;
                default: e_led = 2'b00;
            endcase
            e_valid = (i >= 0);
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        reset_mcu = 1'b1;
        j = '1;
        mcu_mute = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            i2s_mcu_bck = ~i2s_mcu_bck;
        end
        @(posedge clk); #1;
        for (int n = 1; n <= IDLE + 4; n++) begin
            @(posedge clk); #1;
            if (n == IDLE + 1) begin
                checks++;
                if (led[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_before got led1=%b exp 1", led[1]);
                end
`ifdef SNOS_MUTE_ON_IDLE_EN
                checks++;
                if (dac_mute !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_mute_before got %b exp 0", dac_mute);
                end
`endif
            end
            if (n == IDLE + 2) begin
                checks++;
                if (led[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after got led1=%b exp 0", led[1]);
                end
            end
            if (n == IDLE + 4) begin
                checks++;
`ifdef SNOS_MUTE_ON_IDLE_EN
                if (dac_mute !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_mute got %b exp 1", dac_mute);
                end
`else
                if (dac_mute !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_mute got %b exp 0", dac_mute);
                end
`endif
            end
        end
    endtask

    initial begin
        mclk_in = 1'b0;
        pll_clkout = 1'b0;
        test_reset();
        test_i2s_passthrough();
        test_control();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
